// File: rtl/ddr2_line_ctrl_pkg.sv
// Shared types and constants for the DDR2 line controller.
package ddr2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_CMD  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // A line is one BL8 burst of 16-bit words: 8 app addresses per line.
  localparam int BURST_SHIFT = 3;

  // States in which a transaction is outstanding toward the MIG.
  function automatic logic in_flight(state_t s);
    return (s == WR) || (s == RD_CMD) || (s == RD_WAIT);
  endfunction

endpackage

// File: rtl/ddr2_line_ctrl_if.sv
// Requester-side and MIG-side bundles for the DDR2 line controller.
// ddr2_req_if : master = cache/CPU, slave = line controller.
// ddr2_app_if : master = line controller, slave = MIG wrapper.
interface ddr2_req_if #(
  parameter int LINE_AW = 24,
  parameter int DATA_W  = 128
);
  logic               req_valid;
  logic               req_we;
  logic [LINE_AW-1:0] req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_ready;
  logic               resp_valid;
  logic [DATA_W-1:0]  resp_rdata;
  logic               busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

interface ddr2_app_if #(
  parameter int APP_AW = 27,
  parameter int DATA_W = 128
);
  logic              calib_done;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [APP_AW-1:0] app_addr;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    input  calib_done, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end
  );
  modport slave (
    output calib_done, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr2_line_ctrl_wdog.sv
// Stall watchdog: counts cycles spent in one waiting state and flags
// expiry on the last allowed cycle so the FSM can bail out.
module ddr2_line_ctrl_wdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic state_chg,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Cycle count within the current state; restarts on every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (state_chg || !armed) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  // cnt == k during the (k+1)-th cycle in the state.
  assign expired = armed && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ddr2_line_ctrl.sv
// DDR2 line controller: sequences one 128-bit line read/write at a time
// onto the MIG application port and returns a one-cycle response.
// Optional stall watchdog: define DDR2_LINE_CTRL_TIMEOUT_EN.
module ddr2_line_ctrl
  import ddr2_pkg::*;
#(
  parameter int LINE_AW        = 24,
  parameter int APP_AW         = 27,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         sys_clk_i,
  input  logic         sys_rst,
  ddr2_req_if.slave    req,
  ddr2_app_if.master   app
`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  state_t            state, state_n;
  logic              accept;
  logic              tmo;
  logic              app_en_q, wren_q;
  logic [2:0]        app_cmd_q;
  logic [APP_AW-1:0] app_addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              cmd_done, dat_done;

  // Line index -> app address (one burst per line), fitted to APP_AW.
  localparam int CAT_W = LINE_AW + BURST_SHIFT;
  logic [CAT_W-1:0]  addr_cat;
  logic [APP_AW-1:0] addr_map;
  assign addr_cat = {req.req_addr, {BURST_SHIFT{1'b0}}};
  generate
    if (CAT_W >= APP_AW) begin : g_trunc
      assign addr_map = addr_cat[APP_AW-1:0];
    end else begin : g_ext
      assign addr_map = {{(APP_AW-CAT_W){1'b0}}, addr_cat};
    end
  endgenerate

  assign req.req_ready  = (state == IDLE) && app.calib_done;
  assign accept         = req.req_valid && req.req_ready;
  assign req.resp_valid = (state == RESP);
  assign req.resp_rdata = rdata_q;
  assign req.busy       = in_flight(state);

  assign app.app_en       = app_en_q;
  assign app.app_cmd      = app_cmd_q;
  assign app.app_addr     = app_addr_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;

`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
  ddr2_line_ctrl_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (sys_clk_i),
    .rst       (sys_rst),
    .armed     (in_flight(state)),
    .state_chg (state_n != state),
    .expired   (tmo)
  );

  // Sticky error flag; only reset clears it.
  always_ff @(posedge sys_clk_i or posedge sys_rst) begin
    if (sys_rst)  timeout_err <= 1'b0;
    else if (tmo) timeout_err <= 1'b1;
  end
`else
  assign tmo = 1'b0;
  // Keeps the watchdog limit referenced when the feature is compiled out.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // State register.
  always_ff @(posedge sys_clk_i or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic; a watchdog expiry forces a (zero-data) response.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = req.req_we ? WR : RD_CMD;
      WR:      if (cmd_done && dat_done) state_n = RESP;
      RD_CMD:  if (app_en_q && app.app_rdy) state_n = RD_WAIT;
      RD_WAIT: if (app.app_rd_data_valid) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = RESP;
  end

  // Registered MIG drive and handshake bookkeeping. Each strobe drops the
  // cycle after its handshake, so nothing combinational reaches app_en/wren.
  always_ff @(posedge sys_clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      app_en_q   <= 1'b0;
      app_cmd_q  <= CMD_RD;
      app_addr_q <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cmd_done   <= 1'b0;
      dat_done   <= 1'b0;
    end else if (accept) begin
      app_en_q   <= 1'b1;
      app_cmd_q  <= req.req_we ? CMD_WR : CMD_RD;
      app_addr_q <= addr_map;
      wren_q     <= req.req_we;
      wdata_q    <= req.req_wdata;
      cmd_done   <= 1'b0;
      dat_done   <= 1'b0;
    end else begin
      if (app_en_q && app.app_rdy) begin
        app_en_q <= 1'b0;
        cmd_done <= 1'b1;
      end
      if (wren_q && app.app_wdf_rdy) begin
        wren_q   <= 1'b0;
        dat_done <= 1'b1;
      end
      if ((state == RD_WAIT) && app.app_rd_data_valid) rdata_q <= app.app_rd_data;
      if (tmo) begin
        app_en_q <= 1'b0;
        wren_q   <= 1'b0;
        rdata_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_line_ctrl.sv
// Scoreboard bench for ddr2_line_ctrl. Timeout scenario runs only when
// DDR2_LINE_CTRL_TIMEOUT_EN is defined.
module tb_ddr2_line_ctrl;
  localparam int LINE_AW = 24;
  localparam int APP_AW  = 27;
  localparam int DATA_W  = 128;
`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
  localparam int RD_LAT  = 10;
`else
  localparam int RD_LAT  = 20;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr2_req_if #(.LINE_AW(LINE_AW), .DATA_W(DATA_W)) rq ();
  ddr2_app_if #(.APP_AW(APP_AW), .DATA_W(DATA_W))   ap ();
`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
  logic timeout_err;
`endif

  ddr2_line_ctrl #(
    .LINE_AW(LINE_AW), .APP_AW(APP_AW), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst   (rst),
    .req       (rq),
    .app       (ap)
`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t              sb[$];
  exp_t              e;
  logic [DATA_W-1:0] last_rd = '0;
  logic [DATA_W-1:0] next_rd = '0;
  logic [DATA_W-1:0] ex;

  int cyc = 0;
  int resp_cnt, en_cyc, wren_cyc, en_rise, wren_rise;
  int acc_cyc, resp_cyc, cmd_acc_cyc, dat_acc_cyc;
  logic [APP_AW-1:0] cap_addr;
  logic [2:0]        cap_cmd;
  logic [DATA_W-1:0] cap_wdata;
  logic              en_prev = 1'b0, wren_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pushes expectations on accept, pops and checks on response.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_rd   = '0;
      en_prev   = 1'b0;
      wren_prev = 1'b0;
    end else begin
      if (rq.req_valid && rq.req_ready) begin
        sb.push_back(exp_t'{we: rq.req_we, rdata: next_rd});
        acc_cyc = cyc;
      end
      if (ap.app_en) begin
        en_cyc++;
        if (!en_prev) begin
          en_rise++;
          cap_addr = ap.app_addr;
          cap_cmd  = ap.app_cmd;
        end
        if (ap.app_rdy) cmd_acc_cyc = cyc;
      end
      if (ap.app_wdf_wren) begin
        wren_cyc++;
        chk("wdf_end", ap.app_wdf_end, 1);
        if (!wren_prev) begin
          wren_rise++;
          cap_wdata = ap.app_wdf_data;
        end
        if (ap.app_wdf_rdy) dat_acc_cyc = cyc;
      end
      if (rq.resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        chk("resp_ready_low", rq.req_ready, 0);
        chk("resp_outstanding", sb.size(), 1);
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          ex = e.we ? last_rd : e.rdata;
          chk("resp_rdata", rq.resp_rdata, ex);
          if (!e.we) last_rd = e.rdata;
        end
      end
      en_prev   = ap.app_en;
      wren_prev = ap.app_wdf_wren;
    end
  end

  task automatic clr_stats();
    resp_cnt = 0; en_cyc = 0; wren_cyc = 0; en_rise = 0; wren_rise = 0;
    acc_cyc = 0; resp_cyc = 0; cmd_acc_cyc = 0; dat_acc_cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic issue(input logic we, input logic [LINE_AW-1:0] addr, input logic [DATA_W-1:0] wd);
    bit ok = 0;
    @(posedge clk); #1;
    rq.req_valid = 1'b1; rq.req_we = we; rq.req_addr = addr; rq.req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rq.req_ready) begin ok = 1; break; end
    end
    chk("accept_seen", ok, 1);
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (resp_cnt >= target) break;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, rq.req_ready, 0);
    chk({tag, "_resp_valid"}, rq.resp_valid, 0);
    chk({tag, "_resp_rdata"}, rq.resp_rdata, 0);
    chk({tag, "_busy"}, rq.busy, 0);
    chk({tag, "_app_en"}, ap.app_en, 0);
    chk({tag, "_app_cmd"}, ap.app_cmd, 3'b001);
    chk({tag, "_app_addr"}, ap.app_addr, 0);
    chk({tag, "_wdf_data"}, ap.app_wdf_data, 0);
    chk({tag, "_wdf_wren"}, ap.app_wdf_wren, 0);
    chk({tag, "_wdf_end"}, ap.app_wdf_end, 0);
`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
    chk({tag, "_timeout_err"}, timeout_err, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DATA_W-1:0] rd_val;
    rst = 1'b1;
    rq.req_valid = 0; rq.req_we = 0; rq.req_addr = '0; rq.req_wdata = '0;
    ap.calib_done = 0; ap.app_rdy = 1; ap.app_wdf_rdy = 1;
    ap.app_rd_data = '0; ap.app_rd_data_valid = 0;
    clr_stats();
    idle(2);
    chk_reset_outs("rst");
    rst = 1'b0;
    ap.calib_done = 1'b1;
    idle(2);

    // Write with the MIG always ready.
    clr_stats();
    issue(1'b1, 24'h000010, {16{8'hA5}});
    wait_resp(1);
    idle(3);
    chk("w1_addr", cap_addr, 27'h80);
    chk("w1_cmd", cap_cmd, 3'b000);
    chk("w1_wdata", cap_wdata, {16{8'hA5}});
    chk("w1_en_cycles", en_cyc, 1);
    chk("w1_wren_cycles", wren_cyc, 1);
    chk("w1_latency", resp_cyc - acc_cyc, 3);
    chk("w1_resp_cnt", resp_cnt, 1);
    chk("w1_busy_after", rq.busy, 0);

    // Write with split handshakes: command accepted before data.
    clr_stats();
    ap.app_rdy = 0; ap.app_wdf_rdy = 0;
    issue(1'b1, 24'h000055, {4{32'hDEADBEEF}});
    chk("w2_busy", rq.busy, 1);
    repeat (2) @(posedge clk); #1 ap.app_rdy = 1;
    repeat (3) @(posedge clk); #1 ap.app_wdf_rdy = 1;
    wait_resp(1);
    idle(3);
    chk("w2_en_cycles", en_cyc, 3);
    chk("w2_wren_cycles", wren_cyc, 6);
    chk("w2_en_rise", en_rise, 1);
    chk("w2_wren_rise", wren_rise, 1);
    chk("w2_dat_after_cmd", dat_acc_cyc - cmd_acc_cyc, 3);
    chk("w2_latency", resp_cyc - acc_cyc, 8);
    chk("w2_resp_cnt", resp_cnt, 1);

    // Stray read data while idle must be ignored.
    clr_stats();
    ap.app_rd_data = {4{32'hBAD0BAD0}}; ap.app_rd_data_valid = 1;
    @(posedge clk); #1 ap.app_rd_data_valid = 0;
    idle(3);
    chk("stray_resp_cnt", resp_cnt, 0);
    chk("stray_rdata", rq.resp_rdata, last_rd);

    // Read with RD_LAT cycles of MIG latency.
    clr_stats();
    rd_val  = 128'h0123456789ABCDEF0123456789ABCDEF;
    next_rd = rd_val;
    issue(1'b0, 24'h000003, '0);
    repeat (RD_LAT - 1) @(posedge clk);
    #1;
    chk("r1_busy", rq.busy, 1);
    chk("r1_no_early_resp", resp_cnt, 0);
    ap.app_rd_data = rd_val; ap.app_rd_data_valid = 1;
    @(posedge clk); #1 ap.app_rd_data_valid = 0; ap.app_rd_data = '0;
    wait_resp(1);
    idle(3);
    chk("r1_addr", cap_addr, 27'h18);
    chk("r1_cmd", cap_cmd, 3'b001);
    chk("r1_en_cycles", en_cyc, 1);
    chk("r1_wren_cycles", wren_cyc, 0);
    chk("r1_resp_cnt", resp_cnt, 1);
    chk("r1_rdata_held", rq.resp_rdata, rd_val);

    // Calibration gating, then acceptance the cycle calib_done rises.
    clr_stats();
    ap.calib_done = 0;
    rq.req_valid = 1; rq.req_we = 1; rq.req_addr = 24'h000007; rq.req_wdata = {4{32'h600DF00D}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cal_ready_low", rq.req_ready, 0);
      chk("cal_no_app_en", ap.app_en, 0);
    end
    @(posedge clk); #1 ap.calib_done = 1;
    @(negedge clk);
    chk("cal_ready_rise", rq.req_ready, 1);
    @(posedge clk); #1 rq.req_valid = 0;
    wait_resp(1);
    idle(3);
    chk("cal_addr", cap_addr, 27'h38);
    chk("cal_resp_cnt", resp_cnt, 1);

    // Reset in RD_WAIT abandons the read.
    clr_stats();
    next_rd = {4{32'h13579BDF}};
    issue(1'b0, 24'h000ABC, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("rr_busy", rq.busy, 1);
    rst = 1'b1; ap.calib_done = 0;
    #1;
    chk_reset_outs("midrst");
    idle(2);
    rst = 1'b0; ap.calib_done = 1;
    idle(1);
    ap.app_rd_data = next_rd; ap.app_rd_data_valid = 1;
    @(posedge clk); #1 ap.app_rd_data_valid = 0;
    idle(10);
    chk("rr_resp_cnt", resp_cnt, 0);
    chk("rr_rdata", rq.resp_rdata, 0);

`ifdef DDR2_LINE_CTRL_TIMEOUT_EN
    // Read whose data never arrives: watchdog returns a zero response.
    clr_stats();
    next_rd = '0;
    issue(1'b0, 24'h000009, '0);
    wait_resp(1);
    idle(2);
    chk("to_err", timeout_err, 1);
    chk("to_resp_cnt", resp_cnt, 1);
    chk("to_latency", resp_cyc - acc_cyc, 18);
    chk("to_rdata", rq.resp_rdata, 0);
    chk("to_idle_ready", rq.req_ready, 1);
    chk("to_app_en", ap.app_en, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
